// File: rtl/usb_gpx_conditioner.sv
// GPX pin front end: two-flop synchroniser, counter glitch filter,
// edge capture with maskable IRQ and a 4-word Avalon-MM slave.
module usb_gpx_conditioner #(
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8,
  parameter int EDGE_MODE     = 0,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_port,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        gpx_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             edge_cap_q, edge_cap_d;
  logic             irq_mask_q, irq_mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             commit;
  logic             capture;
  logic             unused_wdata;

  assign unused_wdata = ^writedata[31:1];

  // Filter: count consecutive mismatching samples, commit at the limit
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    commit  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      commit  = 1'b1;
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Decide whether a commit is the edge direction we capture
  always_comb begin
    capture = 1'b0;
    if (EDGE_MODE == 0)
      capture = commit & sync2_q;
    else if (EDGE_MODE == 1)
      capture = commit & ~sync2_q;
    else
      capture = commit;
  end

  // Register writes; a capture beats a same-cycle W1C clear
  always_comb begin
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q;
    if (write && address == 2'd1)
      irq_mask_d = writedata[0];
    if (write && address == 2'd2 && writedata[0])
      edge_cap_d = 1'b0;
    if (capture)
      edge_cap_d = 1'b1;
  end

  // Read mux, registered every cycle from pre-edge register values
  always_comb begin
    readdata_d = '0;
    unique case (address)
      2'd0: readdata_d[0] = level_q;
      2'd1: readdata_d[0] = irq_mask_q;
      2'd2: readdata_d[0] = edge_cap_q;
      2'd3: readdata_d[0] = sync2_q;
      default: readdata_d = '0;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cnt_q      <= '0;
      level_q    <= RESET_LEVEL;
      edge_cap_q <= 1'b0;
      irq_mask_q <= 1'b0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      edge_cap_q <= edge_cap_d;
      irq_mask_q <= irq_mask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata  = readdata_q;
  assign gpx_level = level_q;
  assign irq       = edge_cap_q & irq_mask_q;

endmodule
